// File: rtl/lib_switchblock_pkg.sv
//==============================================================================
// Module  : lib_switchblock_pkg
// Brief   : Shared types, constants and index helpers for the DEM switch tree.
// Revision: 1.0 - initial release
//==============================================================================
`default_nettype none

package lib_switchblock_pkg;

    typedef enum logic [1:0] {
        DEM_THERMO = 2'd0,
        DEM_TOGGLE = 2'd1,
        DEM_RANDOM = 2'd2,
        DEM_RSVD   = 2'd3
    } dem_mode_e;

    localparam int DEM_LFSR_W     = 16;
    localparam int DEM_MAX_LAYERS = 6;

    // Breadth-first node number: root is 0, layer k starts at 2^k - 1.
    function automatic int node_idx(input int layer, input int pos);
        return (1 << layer) - 1 + pos;
    endfunction

    // Bit offset of layer 'layer' child outputs inside the flattened tree bus.
    function automatic int bus_off(input int num_layers, input int layer);
        int off;
        off = 0;
        for (int j = 0; j < layer; j++) begin
            off += (2 << j) * (num_layers - j);
        end
        return off;
    endfunction

endpackage

`default_nettype wire

// File: rtl/dem_switch_node.sv
//==============================================================================
// Module  : dem_switch_node
// Brief   : One DEM switching node: splits v into two registered halves.
// Revision: 1.0 - initial release
//==============================================================================
`default_nettype none

module dem_switch_node
    import lib_switchblock_pkg::*;
#(
    parameter int IN_W = 2
) (
    input  logic            clk_i,
    input  logic            reset_i,
    input  logic            valid_i,
    input  logic [IN_W-1:0] v_i,
    input  dem_mode_e       mode_i,
    input  logic            rnd_i,
    output logic [IN_W-2:0] upper_o,
    output logic [IN_W-2:0] lower_o
);

    logic [IN_W-2:0] w_half;
    logic            w_odd;
    logic            w_to_lower;
    logic            w_toggle;
    logic [IN_W-2:0] r_upper;
    logic [IN_W-2:0] r_lower;
    logic            r_state;

    assign w_half   = v_i[IN_W-1:1];
    assign w_odd    = v_i[0];
    assign w_toggle = (mode_i == DEM_TOGGLE) || (mode_i == DEM_RSVD);

    always_comb begin
        w_to_lower = 1'b0;
        case (mode_i)
            DEM_THERMO: w_to_lower = 1'b0;
            DEM_RANDOM: w_to_lower = rnd_i;
            default:    w_to_lower = r_state;
        endcase
    end

    always_ff @(posedge clk_i) begin
        if (reset_i) begin
            r_upper <= '0;
            r_lower <= '0;
            r_state <= 1'b0;
        end else begin
            if (valid_i) begin
                r_upper <= w_half + (IN_W-1)'(w_odd & ~w_to_lower);
                r_lower <= w_half + (IN_W-1)'(w_odd & w_to_lower);
            end else begin
                r_upper <= '0;
                r_lower <= '0;
            end
            if (valid_i && w_odd && w_toggle) begin
                r_state <= ~r_state;
            end
        end
    end

    assign upper_o = r_upper;
    assign lower_o = r_lower;

endmodule

`default_nettype wire

// File: rtl/dem_switch_tree.sv
//==============================================================================
// Module  : dem_switch_tree
// Brief   : Pipelined tree DEM encoder, NUM_LAYERS layers -> 2^NUM_LAYERS
//           element enables. Define DEM_LFSR_EN to enable the RANDOM mode LFSR.
// Revision: 1.0 - initial release
//==============================================================================
`default_nettype none

module dem_switch_tree
    import lib_switchblock_pkg::*;
#(
    parameter int          NUM_LAYERS = 3,
    parameter int          CODE_W     = NUM_LAYERS + 1,
    parameter logic [15:0] LFSR_SEED  = 16'hACE1
) (
    input  logic                      clk_i,
    input  logic                      reset_i,
    input  logic                      valid_i,
    input  logic [CODE_W-1:0]         x_i,
    input  logic [1:0]                mode_i,
    output logic                      valid_o,
    output logic [(1<<NUM_LAYERS)-1:0] elements_o,
    output logic                      ovf_o
);

    localparam int                c_NUM_EL = 1 << NUM_LAYERS;
    localparam int                c_NODES  = c_NUM_EL - 1;
    localparam int                c_TREE_W = bus_off(NUM_LAYERS, NUM_LAYERS);
    localparam logic [CODE_W-1:0] c_MAX    = CODE_W'(c_NUM_EL);

    logic                  w_ovf;
    logic [NUM_LAYERS:0]   w_clamped;
    dem_mode_e             w_mode;
    logic [c_NODES-1:0]    w_rnd;
    logic [c_TREE_W-1:0]   w_tree;

    logic [NUM_LAYERS:0]   r_valid;
    logic [NUM_LAYERS:0]   r_ovf;
    logic [NUM_LAYERS:0]   r_code;
    dem_mode_e             r_mode [NUM_LAYERS];
    logic [c_NODES-1:0]    r_rnd  [NUM_LAYERS];

    assign w_ovf     = (x_i > c_MAX);
    assign w_clamped = w_ovf ? (NUM_LAYERS+1)'(c_NUM_EL) : x_i[NUM_LAYERS:0];

`ifdef DEM_LFSR_EN
    logic [DEM_LFSR_W-1:0] r_lfsr;

    // Fibonacci taps 16,14,13,11; each sample takes the value before the shift.
    always_ff @(posedge clk_i) begin
        if (reset_i) begin
            r_lfsr <= LFSR_SEED;
        end else if (valid_i) begin
            r_lfsr <= {r_lfsr[14:0], r_lfsr[15] ^ r_lfsr[13] ^ r_lfsr[12] ^ r_lfsr[10]};
        end
    end

    always_comb begin
        w_rnd = '0;
        for (int j = 0; j < c_NODES; j++) begin
            w_rnd[j] = r_lfsr[j % DEM_LFSR_W];
        end
    end

    assign w_mode = dem_mode_e'(mode_i);
`else
    assign w_rnd  = '0;
    assign w_mode = (dem_mode_e'(mode_i) == DEM_RANDOM) ? DEM_TOGGLE : dem_mode_e'(mode_i);
`endif

    // Entry stage plus the sideband that travels alongside each tree layer.
    always_ff @(posedge clk_i) begin
        if (reset_i) begin
            r_valid <= '0;
            r_ovf   <= '0;
            r_code  <= '0;
            for (int k = 0; k < NUM_LAYERS; k++) begin
                r_mode[k] <= DEM_THERMO;
                r_rnd[k]  <= '0;
            end
        end else begin
            r_valid   <= {r_valid[NUM_LAYERS-1:0], valid_i};
            r_ovf     <= {r_ovf[NUM_LAYERS-1:0], valid_i & w_ovf};
            r_code    <= valid_i ? w_clamped : '0;
            r_mode[0] <= valid_i ? w_mode : DEM_THERMO;
            r_rnd[0]  <= valid_i ? w_rnd : '0;
            for (int k = 1; k < NUM_LAYERS; k++) begin
                r_mode[k] <= r_mode[k-1];
                r_rnd[k]  <= r_rnd[k-1];
            end
        end
    end

    for (genvar k = 0; k < NUM_LAYERS; k++) begin : g_layer
        localparam int c_IN_W = NUM_LAYERS - k + 1;
        localparam int c_CW   = c_IN_W - 1;
        localparam int c_OFF  = bus_off(NUM_LAYERS, k);

        for (genvar n = 0; n < (1 << k); n++) begin : g_node
            logic [c_IN_W-1:0] w_v;

            if (k == 0) begin : g_root
                assign w_v = r_code;
            end else begin : g_inner
                assign w_v = w_tree[bus_off(NUM_LAYERS, k-1) + n*c_IN_W +: c_IN_W];
            end

            dem_switch_node #(
                .IN_W (c_IN_W)
            ) u_node (
                .clk_i   (clk_i),
                .reset_i (reset_i),
                .valid_i (r_valid[k]),
                .v_i     (w_v),
                .mode_i  (r_mode[k]),
                .rnd_i   (r_rnd[k][node_idx(k, n)]),
                .upper_o (w_tree[c_OFF + (2*n)*c_CW +: c_CW]),
                .lower_o (w_tree[c_OFF + (2*n+1)*c_CW +: c_CW])
            );
        end
    end

    assign valid_o    = r_valid[NUM_LAYERS];
    assign ovf_o      = r_ovf[NUM_LAYERS];
    assign elements_o = w_tree[bus_off(NUM_LAYERS, NUM_LAYERS-1) +: c_NUM_EL];

endmodule

`default_nettype wire

// File: tb/tb_dem_switch_tree.sv
//==============================================================================
// Module  : tb_dem_switch_tree
// Brief   : Self-checking bench for dem_switch_tree (NUM_LAYERS=3, default build).
// Revision: 1.0 - initial release
//==============================================================================
`default_nettype none

module tb_dem_switch_tree;

    localparam int NUM_LAYERS = 3;
    localparam int NUM_EL     = 8;
    localparam int CODE_W     = 4;
    localparam int LAT        = NUM_LAYERS + 1;

    logic              clk = 1'b0;
    logic              reset_i;
    logic              valid_i;
    logic [CODE_W-1:0] x_i;
    logic [1:0]        mode_i;
    logic              valid_o;
    logic [NUM_EL-1:0] elements_o;
    logic              ovf_o;

    int n_checks = 0;
    int n_errors = 0;

    dem_switch_tree #(
        .NUM_LAYERS (NUM_LAYERS),
        .CODE_W     (CODE_W),
        .LFSR_SEED  (16'hACE1)
    ) u_dut (
        .clk_i      (clk),
        .reset_i    (reset_i),
        .valid_i    (valid_i),
        .x_i        (x_i),
        .mode_i     (mode_i),
        .valid_o    (valid_o),
        .elements_o (elements_o),
        .ovf_o      (ovf_o)
    );

    always #5 clk = ~clk;

    // Reference: toggle bit per node in breadth-first order, plus expected-output pipeline.
    bit              tog [NUM_EL-1];
    bit              p_v [LAT];
    logic [NUM_EL-1:0] p_e [LAT];
    bit              p_o [LAT];
    int              p_n [LAT];
    bit              p_hc[LAT];
    logic [NUM_EL-1:0] p_c [LAT];

    task automatic model_sample(input int x, input int mode,
                                output logic [NUM_EL-1:0] e, output bit o, output int cnt);
        int  cur [NUM_EL];
        int  nxt [NUM_EL];
        int  v, idx;
        bit  lower;
        cnt = (x > NUM_EL) ? NUM_EL : x;
        o   = (x > NUM_EL);
        for (int i = 0; i < NUM_EL; i++) cur[i] = 0;
        cur[0] = cnt;
        for (int k = 0; k < NUM_LAYERS; k++) begin
            for (int i = 0; i < NUM_EL; i++) nxt[i] = 0;
            for (int n = 0; n < (1 << k); n++) begin
                v     = cur[n];
                idx   = (1 << k) - 1 + n;
                lower = 1'b0;
                // RANDOM without the LFSR and reserved both fall back to toggling.
                if ((v % 2) == 1 && mode != 0) begin
                    lower    = tog[idx];
                    tog[idx] = !tog[idx];
                end
                nxt[2*n]   = v / 2 + (((v % 2) == 1 && !lower) ? 1 : 0);
                nxt[2*n+1] = v / 2 + (((v % 2) == 1 && lower) ? 1 : 0);
            end
            cur = nxt;
        end
        e = '0;
        for (int i = 0; i < NUM_EL; i++) e[i] = (cur[i] != 0);
    endtask

    task automatic step(input bit rst, input bit v, input int x, input int mode,
                        input bit hc, input logic [NUM_EL-1:0] cv);
        logic [NUM_EL-1:0] e;
        bit                o;
        int                cnt;
        reset_i = rst;
        valid_i = v;
        x_i     = x[CODE_W-1:0];
        mode_i  = mode[1:0];
        for (int i = LAT-1; i > 0; i--) begin
            p_v[i] = p_v[i-1]; p_e[i] = p_e[i-1]; p_o[i] = p_o[i-1];
            p_n[i] = p_n[i-1]; p_hc[i] = p_hc[i-1]; p_c[i] = p_c[i-1];
        end
        p_v[0] = 0; p_e[0] = '0; p_o[0] = 0; p_n[0] = 0; p_hc[0] = 0; p_c[0] = '0;
        if (rst) begin
            for (int i = 0; i < LAT; i++) begin
                p_v[i] = 0; p_e[i] = '0; p_o[i] = 0; p_n[i] = 0; p_hc[i] = 0;
            end
            for (int i = 0; i < NUM_EL-1; i++) tog[i] = 0;
        end else if (v) begin
            model_sample(x, mode, e, o, cnt);
            p_v[0] = 1; p_e[0] = e; p_o[0] = o; p_n[0] = cnt; p_hc[0] = hc; p_c[0] = cv;
        end
        @(posedge clk);
        #1;
        n_checks++;
        assert (valid_o === p_v[LAT-1]) else begin
            n_errors++;
            $error("FAIL valid_o got %0b exp %0b", valid_o, p_v[LAT-1]);
        end
        n_checks++;
        assert (elements_o === p_e[LAT-1]) else begin
            n_errors++;
            $error("FAIL elements_o got %h exp %h", elements_o, p_e[LAT-1]);
        end
        n_checks++;
        assert (ovf_o === p_o[LAT-1]) else begin
            n_errors++;
            $error("FAIL ovf_o got %0b exp %0b", ovf_o, p_o[LAT-1]);
        end
        if (p_v[LAT-1]) begin
            n_checks++;
            assert ($countones(elements_o) == p_n[LAT-1]) else begin
                n_errors++;
                $error("FAIL popcount got %0d exp %0d", $countones(elements_o), p_n[LAT-1]);
            end
        end
        if (p_v[LAT-1] && p_hc[LAT-1]) begin
            n_checks++;
            assert (elements_o === p_c[LAT-1]) else begin
                n_errors++;
                $error("FAIL directed_elements got %h exp %h", elements_o, p_c[LAT-1]);
            end
        end
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) step(0, 0, 0, 0, 0, '0);
    endtask

    logic [NUM_EL-1:0] tog_seq [8];

    initial begin
        reset_i = 1'b1;
        valid_i = 1'b0;
        x_i     = '0;
        mode_i  = '0;
        tog_seq = '{8'h01, 8'h10, 8'h04, 8'h40, 8'h02, 8'h20, 8'h08, 8'h80};

        step(1, 0, 0, 0, 0, '0);
        step(1, 0, 0, 0, 0, '0);
        idle(2);

        // Full scale and partial thermometer codes.
        step(0, 1, 8, 0, 1, 8'hFF);
        idle(LAT);
        step(0, 1, 3, 0, 1, 8'h15);
        idle(LAT);

        // Single-unit toggle rotation through every element.
        for (int i = 0; i < 8; i++) step(0, 1, 1, 1, 1, tog_seq[i]);
        idle(LAT);

        // Overflow clamp in each mode.
        for (int m = 0; m < 4; m++) step(0, 1, 12, m, 1, 8'hFF);
        step(0, 1, 15, 1, 1, 8'hFF);
        idle(LAT);

        // Reset while samples are in flight.
        step(0, 1, 1, 1, 0, '0);
        step(0, 1, 1, 1, 0, '0);
        step(1, 0, 0, 0, 0, '0);
        step(0, 1, 1, 1, 1, 8'h01);
        idle(LAT);

        // x=5 toggle: gap-free then with random bubbles, each from reset.
        step(1, 0, 0, 0, 0, '0);
        for (int i = 0; i < 8; i++) step(0, 1, 5, 1, 0, '0);
        idle(LAT);
        step(1, 0, 0, 0, 0, '0);
        for (int i = 0; i < 30; i++) step(0, bit'($urandom_range(0, 1)), 5, 1, 0, '0);
        idle(LAT);

        // Random codes, modes and bubbles.
        for (int i = 0; i < 400; i++) begin
            step(0, ($urandom_range(0, 3) != 0), int'($urandom_range(0, 15)),
                 int'($urandom_range(0, 3)), 0, '0);
        end
        idle(LAT + 1);

        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end

endmodule

`default_nettype wire

// File: doc/dem_switch_tree.md
Name: dem_switch_tree

Overview:
- Parametrised tree-structured dynamic-element-matching encoder for a unit-element DAC.
- Takes one input code per valid cycle and splits it recursively through NUM_LAYERS layers of switching nodes into 2^NUM_LAYERS one-bit element enables.
- Each layer is registered.
- Per-node state shapes element mismatch according to the selected mode.
- Generalises the fixed 3-layer, 8-output switching block to any depth, and adds a valid pipeline, selectable split modes and overflow clamping.

Parameters:
- NUM_LAYERS, 3: tree depth. Number of elements is NUM_EL = 2^NUM_LAYERS. Legal range 1..6.
- CODE_W, NUM_LAYERS+1: input code width. Must be ≥ NUM_LAYERS+1.
- LFSR_SEED, 16'hACE1: reset value of the random-split LFSR. Used only with DEM_LFSR_EN.

Ports:
- clk_i  in  1  clock.
- reset_i  in  1  synchronous, active-high reset.
- valid_i  in  1  x_i is a sample this cycle.
- x_i  in  CODE_W  unsigned code, nominal range 0..NUM_EL.
- mode_i  in  2  split mode: 0 THERMO, 1 TOGGLE, 2 RANDOM, 3 reserved (treated as TOGGLE).
- valid_o  out  1  elements_o is a sample.
- elements_o  out  NUM_EL  unit-element enables; bit n drives element n.
- ovf_o  out  1  the sample now on elements_o was clamped.

Behaviour:
- Interface (already decided): one clock, clk_i; reset_i is synchronous and active-high.
- Reset: all pipeline registers, valid_o, elements_o and ovf_o are 0. All node state bits are 0. The LFSR loads LFSR_SEED.
- Reset mid-operation: samples in flight are discarded and no valid_o is produced for them. The state after reset equals power-up state.
- Entry stage, on valid_i:
  - clamp x_i > NUM_EL to NUM_EL and set the ovf flag.
  - capture mode_i with the sample. Mode travels down the pipeline, so each sample is split under a single mode.
- Node at layer k (root k=0) receives value v in 0..2^(NUM_LAYERS-k).
  - v even: both children get v/2.
  - v odd: children get floor(v/2), plus one extra unit to child 2n (upper) or 2n+1 (lower), chosen per mode:
    - THERMO: always upper. Node state is not modified.
    - TOGGLE: upper if state s=0, else lower; s toggles.
    - RANDOM: the LFSR bit assigned to that node selects; s is untouched.
- Node state updates only on a valid sample with odd v. Bubbles (valid low) do not change any state.
- Widths: a layer-k node output is NUM_LAYERS-k bits wide. Leaf outputs are 1 bit each, concatenated into elements_o.
- Latency: exactly NUM_LAYERS+1 cycles from valid_i to valid_o (entry register plus one register per layer). Throughput is one sample per cycle.
- Invariants:
  - valid_o matches valid_i delayed by NUM_LAYERS+1.
  - popcount(elements_o) equals the clamped code.
  - When valid_o=0, elements_o and ovf_o are 0.
- Mode change between samples is allowed. Toggle states persist across THERMO/RANDOM samples.

Optional Feature:
- DEM_LFSR_EN defined: instantiates a 16-bit Fibonacci LFSR (taps 16,14,13,11). It advances once per valid input, and its low NUM_EL-1 bits feed the nodes.
- DEM_LFSR_EN undefined: no LFSR logic; mode 2 behaves exactly as TOGGLE.

Decomposition:
- lib_switchblock_pkg gets:
  - typedef enum logic [1:0] dem_mode_e {DEM_THERMO, DEM_TOGGLE, DEM_RANDOM, DEM_RSVD}.
  - constants DEM_LFSR_W=16 and DEM_MAX_LAYERS=6.
  - function clog2-free node-index helper node_idx(layer, pos).
- Sub-module dem_switch_node (parameter IN_W):
  - combinational split plus registered children, valid and mode.
  - one state flip-flop.
  - generated 2^k times at layer k.

Test Plan (NUM_LAYERS=3):
- Reset, then x=8, THERMO, single valid → after 4 cycles valid_o=1, elements_o=8'hFF, ovf_o=0. The next cycle has valid_o=0 and elements_o=0.
- x=3, THERMO → elements_o=8'h15 (elements 0, 2, 4).
- x=1, TOGGLE, 8 back-to-back samples → active element sequence 0,4,2,6,1,5,3,7, each used once.
- x=12, any mode → elements_o=8'hFF, ovf_o=1 aligned with valid_o.
- TOGGLE x=1 ×2, assert reset_i for 1 cycle mid-stream, then x=1 → no valid_o for in-flight samples; first post-reset output selects element 0.
- Random valid_i gaps with x=5, TOGGLE → popcount=5 on every valid_o. Element sequence is identical to the gap-free run. Latency is always 4.
